// File: rtl/cache_fill_pkg.sv
// Shared types and geometry helpers for the cache-line fill controller.
// Widths are derived from line geometry so every block agrees on them.
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  function automatic int calc_idx_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int calc_off_w(input int line_words, input int word_bytes);
    return $clog2(line_words * word_bytes);
  endfunction

  function automatic int calc_wb_w(input int word_bytes);
    return $clog2(word_bytes);
  endfunction

endpackage

// File: rtl/cache_line_fill_ctrl_counter.sv
// Clear/increment word counter; word_idx is the wrapped line index (start + count).
// Updates one cycle after inc; clr has priority over inc.
module fill_word_counter
  import cache_fill_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W:0]   cnt,
  output logic [IDX_W-1:0] word_idx
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + (IDX_W + 1)'(1);
    end
  end

  // Dropping the carry gives the mod-LINE_WORDS wrap for free.
  assign word_idx = start + cnt[IDX_W-1:0];

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Line fill controller: one read request per word under valid/ready, in-order responses
// written straight into the data array; first request one cycle after the miss, held under backpressure.
module cache_line_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 2,
  parameter int LINE_WORDS = 8,
  parameter bit CWF        = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_req_ready,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] memory_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_address,
  output logic              fill_done
);

  localparam int IDX_W = calc_idx_w(LINE_WORDS);
  localparam int OFF_W = calc_off_w(LINE_WORDS, WORD_BYTES);
  localparam int WB_W  = calc_wb_w(WORD_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * WORD_BYTES - 1);
  localparam logic [IDX_W:0]    N_WORDS  = (IDX_W + 1)'(LINE_WORDS);
  localparam logic [IDX_W:0]    LAST_IDX = (IDX_W + 1)'(LINE_WORDS - 1);

  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  start;
  logic [IDX_W-1:0]  crit_idx;
  logic              capture;
  logic              req_fire;
  logic [IDX_W:0]    req_cnt, rsp_cnt;
  logic [IDX_W-1:0]  req_idx, rsp_idx;

  generate
    if (CWF) begin : g_cwf
      assign crit_idx = miss_address[OFF_W-1:WB_W];
    end else begin : g_linear
      assign crit_idx = '0;
    end
  endgenerate

  assign capture = (state == IDLE) && miss_detected;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
      start <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        base  <= miss_address & ~OFF_MASK;
        start <= crit_idx;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    mem_req_valid    = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;
    case (state)
      IDLE: if (miss_detected) state_nxt = FILL;
      FILL: begin
        mem_req_valid = (req_cnt < N_WORDS);
        // A response with nothing outstanding is stale and must not be written.
        write_data_array = memory_data_valid && (rsp_cnt < req_cnt);
        write_tag_array  = write_data_array && (rsp_cnt == LAST_IDX);
        if (write_tag_array) state_nxt = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_fire = mem_req_valid && mem_req_ready;
  assign fsm_busy = (state != IDLE) || miss_detected;

  fill_word_counter #(.IDX_W(IDX_W)) u_req_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (capture),
    .inc      (req_fire),
    .start    (start),
    .cnt      (req_cnt),
    .word_idx (req_idx)
  );

  fill_word_counter #(.IDX_W(IDX_W)) u_rsp_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (capture),
    .inc      (write_data_array),
    .start    (start),
    .cnt      (rsp_cnt),
    .word_idx (rsp_idx)
  );

  // Base is line-aligned, so these sums never carry out of the line.
  assign memory_address = base + (ADDR_W'(req_idx) << WB_W);
  assign cache_address  = base + (ADDR_W'(rsp_idx) << WB_W);

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Bench: two 16-bit instances (linear and critical-word-first) share stimulus against a
// list-based reference; a third 32-bit, 4x4-byte instance gets a directed top-of-memory fill.
module tb_cache_line_fill_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        mem_req_ready = 1'b0;
  logic        memory_data_valid = 1'b0;

  logic        mem_req_valid0, fsm_busy0, write_data_array0, write_tag_array0, fill_done0;
  logic [15:0] memory_address0, cache_address0;
  logic        mem_req_valid1, fsm_busy1, write_data_array1, write_tag_array1, fill_done1;
  logic [15:0] memory_address1, cache_address1;

  logic        miss2 = 1'b0, rdy2 = 1'b0, dv2 = 1'b0;
  logic [31:0] addr2 = '0;
  logic        mem_req_valid2, fsm_busy2, write_data_array2, write_tag_array2, fill_done2;
  logic [31:0] memory_address2, cache_address2;

  cache_line_fill_ctrl #(.ADDR_W(16), .WORD_BYTES(2), .LINE_WORDS(8), .CWF(1'b0)) dut0 (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_req_ready(mem_req_ready), .mem_req_valid(mem_req_valid0), .memory_address(memory_address0),
    .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy0), .write_data_array(write_data_array0),
    .write_tag_array(write_tag_array0), .cache_address(cache_address0), .fill_done(fill_done0));

  cache_line_fill_ctrl #(.ADDR_W(16), .WORD_BYTES(2), .LINE_WORDS(8), .CWF(1'b1)) dut1 (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_req_ready(mem_req_ready), .mem_req_valid(mem_req_valid1), .memory_address(memory_address1),
    .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy1), .write_data_array(write_data_array1),
    .write_tag_array(write_tag_array1), .cache_address(cache_address1), .fill_done(fill_done1));

  cache_line_fill_ctrl #(.ADDR_W(32), .WORD_BYTES(4), .LINE_WORDS(4), .CWF(1'b0)) dut2 (
    .clk(clk), .rst(rst), .miss_detected(miss2), .miss_address(addr2),
    .mem_req_ready(rdy2), .mem_req_valid(mem_req_valid2), .memory_address(memory_address2),
    .memory_data_valid(dv2), .fsm_busy(fsm_busy2), .write_data_array(write_data_array2),
    .write_tag_array(write_tag_array2), .cache_address(cache_address2), .fill_done(fill_done2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: phase 0 idle, 1 filling, 2 done; expected address order held as lists.
  int          ph = 0, nreq = 0, nrsp = 0, cyc = 0;
  logic [15:0] l0[8], l1[8];
  int          pend[$];
  int          rsp_delay = 3;
  bit          rnd_delay = 0;

  logic [15:0] first0, first1, tag0, tag1;
  bit          seen_first;
  int          nreq0, nwr0, nreq1, nwr1, ndone0, ndone1;

  logic        n_miss2 = 1'b0, n_rdy2 = 1'b0, n_dv2 = 1'b0;
  logic [31:0] n_addr2 = '0;

  task automatic step(input logic miss, input logic [15:0] ma, input logic rdy,
                      input logic rst_i, input logic spur);
    logic        dv;
    bit          e_vld, e_wr, e_tag, e_done, e_busy;
    logic [15:0] b;
    int          st;
    @(negedge clk);
    dv = spur;
    if (pend.size() > 0 && pend[0] <= cyc) begin
      dv = 1'b1;
      void'(pend.pop_front());
    end
    rst = rst_i; miss_detected = miss; miss_address = ma;
    mem_req_ready = rdy; memory_data_valid = dv;
    miss2 = n_miss2; addr2 = n_addr2; rdy2 = n_rdy2; dv2 = n_dv2;
    #1;
    e_vld  = (ph == 1) && (nreq < 8);
    e_wr   = (ph == 1) && dv && (nrsp < nreq);
    e_tag  = e_wr && (nrsp == 7);
    e_done = (ph == 2);
    e_busy = (ph != 0) || miss;
    chk("d0 req_valid", 32'(mem_req_valid0), 32'(e_vld));
    chk("d1 req_valid", 32'(mem_req_valid1), 32'(e_vld));
    chk("d0 write_data", 32'(write_data_array0), 32'(e_wr));
    chk("d1 write_data", 32'(write_data_array1), 32'(e_wr));
    chk("d0 write_tag", 32'(write_tag_array0), 32'(e_tag));
    chk("d1 write_tag", 32'(write_tag_array1), 32'(e_tag));
    chk("d0 fill_done", 32'(fill_done0), 32'(e_done));
    chk("d1 fill_done", 32'(fill_done1), 32'(e_done));
    chk("d0 busy", 32'(fsm_busy0), 32'(e_busy));
    chk("d1 busy", 32'(fsm_busy1), 32'(e_busy));
    if (e_vld) begin
      chk("d0 memory_address", 32'(memory_address0), 32'(l0[nreq]));
      chk("d1 memory_address", 32'(memory_address1), 32'(l1[nreq]));
    end
    if (e_wr) begin
      chk("d0 cache_address", 32'(cache_address0), 32'(l0[nrsp]));
      chk("d1 cache_address", 32'(cache_address1), 32'(l1[nrsp]));
    end
    if (mem_req_valid0 && rdy) begin
      nreq0++;
      if (!seen_first) begin
        first0 = memory_address0; first1 = memory_address1; seen_first = 1;
      end
    end
    if (mem_req_valid1 && rdy) nreq1++;
    if (write_data_array0) nwr0++;
    if (write_data_array1) nwr1++;
    if (write_tag_array0) tag0 = cache_address0;
    if (write_tag_array1) tag1 = cache_address1;
    if (fill_done0) ndone0++;
    if (fill_done1) ndone1++;
    if (rst_i) begin
      ph = 0; nreq = 0; nrsp = 0; pend.delete();
    end else begin
      case (ph)
        0: if (miss) begin
          ph = 1; nreq = 0; nrsp = 0;
          b = ma & 16'hFFF0;
          st = int'(ma[3:1]);
          for (int k = 0; k < 8; k++) begin
            l0[k] = b + 16'(2 * k);
            l1[k] = b + 16'(2 * ((st + k) % 8));
          end
        end
        1: begin
          if (e_vld && rdy) begin
            nreq++;
            pend.push_back(cyc + (rnd_delay ? int'($urandom_range(1, 5)) : rsp_delay));
          end
          if (e_wr) nrsp++;
          if (e_tag) begin
            ph = 2; pend.delete();
          end
        end
        default: ph = 0;
      endcase
    end
    cyc++;
  endtask

  task automatic clear_stats();
    seen_first = 0; first0 = 'x; first1 = 'x; tag0 = 'x; tag1 = 'x;
    nreq0 = 0; nwr0 = 0; nreq1 = 0; nwr1 = 0; ndone0 = 0; ndone1 = 0;
  endtask

  task automatic run_fill(input logic [15:0] ma, input int delay, input int stall_after,
                          input int stall_len, input bit mid_miss, input bit rnd,
                          input logic [15:0] x0f, input logic [15:0] x0t,
                          input logic [15:0] x1f, input logic [15:0] x1t);
    int   n, stalls;
    logic rdy, m, spur;
    clear_stats();
    rsp_delay = delay; rnd_delay = rnd;
    step(1'b1, ma, 1'b1, 1'b0, 1'b0);
    n = 0; stalls = 0;
    while (ph != 0 && n < 300) begin
      if (rnd) rdy = ($urandom % 4) != 0;
      else if (nreq == stall_after && stalls < stall_len) begin
        rdy = 1'b0; stalls++;
      end else rdy = 1'b1;
      m = mid_miss && (n == 3);
      spur = rnd && (pend.size() == 0) && (($urandom % 4) == 0);
      step(m, m ? 16'h7770 : 16'h0000, rdy, 1'b0, spur);
      n++;
    end
    chk("fill completes in budget", 32'(ph), 32'd0);
    chk("d0 first request", 32'(first0), 32'(x0f));
    chk("d0 tag address", 32'(tag0), 32'(x0t));
    chk("d1 first request", 32'(first1), 32'(x1f));
    chk("d1 tag address", 32'(tag1), 32'(x1t));
    chk("d0 request count", 32'(nreq0), 32'd8);
    chk("d0 write count", 32'(nwr0), 32'd8);
    chk("d1 request count", 32'(nreq1), 32'd8);
    chk("d1 write count", 32'(nwr1), 32'd8);
    chk("d0 done pulses", 32'(ndone0), 32'd1);
    chk("d1 done pulses", 32'(ndone1), 32'd1);
  endtask

  typedef struct {
    logic [15:0] ma;
    int          delay;
    int          stall_after;
    int          stall_len;
    bit          mid_miss;
    logic [15:0] x0f, x0t, x1f, x1t;
  } vec_t;

  vec_t tbl[4];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ma, b;
    int          st, out2, tag_c, done_c, ndone2, n;
    logic [31:0] r2[$], w2[$];

    tbl[0] = '{16'h1236, 3, 99, 0, 1'b0, 16'h1230, 16'h123E, 16'h1236, 16'h1234};
    tbl[1] = '{16'h123A, 3, 99, 0, 1'b1, 16'h1230, 16'h123E, 16'h123A, 16'h1238};
    tbl[2] = '{16'h5555, 2, 2, 4, 1'b0, 16'h5550, 16'h555E, 16'h5554, 16'h5552};
    tbl[3] = '{16'hFFFF, 5, 1, 2, 1'b0, 16'hFFF0, 16'hFFFE, 16'hFFFE, 16'hFFFC};

    repeat (2) @(posedge clk);
    clear_stats();
    // Miss together with reset: busy follows the miss, but nothing is captured.
    step(1'b1, 16'h1236, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("reset memory_address d0", 32'(memory_address0), 32'd0);
    chk("reset cache_address d0", 32'(cache_address0), 32'd0);
    chk("reset memory_address d1", 32'(memory_address1), 32'd0);
    chk("reset cache_address d1", 32'(cache_address1), 32'd0);
    chk("reset d2 req_valid", 32'(mem_req_valid2), 32'd0);
    chk("reset d2 busy", 32'(fsm_busy2), 32'd0);

    // Responses while idle are ignored.
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++)
      run_fill(tbl[i].ma, tbl[i].delay, tbl[i].stall_after, tbl[i].stall_len, tbl[i].mid_miss,
               1'b0, tbl[i].x0f, tbl[i].x0t, tbl[i].x1f, tbl[i].x1t);

    // Reset after three responses, then stale responses, then a clean fill.
    clear_stats();
    rsp_delay = 1; rnd_delay = 0;
    step(1'b1, 16'h1236, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (nrsp < 3 && n < 50) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("three responses before reset", 32'(nrsp), 32'd3);
    step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("post-reset d0 memory_address", 32'(memory_address0), 32'd0);
    chk("post-reset d0 cache_address", 32'(cache_address0), 32'd0);
    chk("post-reset d1 memory_address", 32'(memory_address1), 32'd0);
    chk("post-reset d1 cache_address", 32'(cache_address1), 32'd0);
    repeat (3) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_fill(16'h0040, 3, 99, 0, 1'b0, 1'b0, 16'h0040, 16'h004E, 16'h0040, 16'h004E);

    for (int i = 0; i < 25; i++) begin
      ma = 16'($urandom);
      b = ma & 16'hFFF0;
      st = int'(ma[3:1]);
      run_fill(ma, 0, 99, 0, 1'($urandom % 2), 1'b1, b, b + 16'd14,
               b + 16'(2 * st), b + 16'(2 * ((st + 7) % 8)));
    end

    // 32-bit, 4 words of 4 bytes at the top of memory.
    out2 = 0; tag_c = -1; done_c = -2; ndone2 = 0;
    n_miss2 = 1'b1; n_addr2 = 32'hFFFF_FFF4; n_rdy2 = 1'b1; n_dv2 = 1'b0;
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("d2 busy in miss cycle", 32'(fsm_busy2), 32'd1);
    n_miss2 = 1'b0; n_addr2 = '0;
    for (int c = 0; c < 30; c++) begin
      n_dv2 = (out2 > 0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      if (mem_req_valid2) begin
        r2.push_back(memory_address2); out2++;
      end
      if (write_data_array2) begin
        w2.push_back(cache_address2); out2--;
        if (write_tag_array2) tag_c = c;
      end
      if (fill_done2) begin
        done_c = c; ndone2++;
      end
    end
    chk("d2 request count", 32'(r2.size()), 32'd4);
    chk("d2 write count", 32'(w2.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < r2.size()) chk("d2 request address", r2[k], 32'hFFFF_FFF0 + 32'(4 * k));
      if (k < w2.size()) chk("d2 write address", w2[k], 32'hFFFF_FFF0 + 32'(4 * k));
    end
    chk("d2 tag on last write", 32'(tag_c >= 0 && w2.size() == 4 && write_tag_c_ok(tag_c, w2.size())), 32'd1);
    chk("d2 done after tag", 32'(done_c), 32'(tag_c + 1));
    chk("d2 done pulses", 32'(ndone2), 32'd1);
    chk("d2 idle at end", 32'(fsm_busy2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic bit write_tag_c_ok(input int c, input int nw);
    return (c >= 0) && (nw == 4);
  endfunction

endmodule

// File: doc/cache_line_fill_ctrl.md
# cache_line_fill_ctrl

Parametrised cache-line fill controller between the cache miss detector and the multi-cycle main memory. On a miss it issues one read request per word of the line under a valid/ready handshake, and tracks the in-order responses independently. It writes each returned word into the data array and writes the tag array with the final word. Unlike the fixed 8×16-bit fill FSM, it generalises line geometry, aligns the line base, applies request backpressure, and optionally fills critical-word-first.

## Interface
- ADDR_W, 16, address width in bits.
- WORD_BYTES, 2, bytes per memory word; power of 2, ≥1.
- LINE_WORDS, 8, words per cache line; power of 2, ≥2.
- CWF, 0, 1 = critical-word-first wrap order; 0 = ascending from word 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache miss this cycle.
- miss_address  in  ADDR_W  byte address of the missing access.
- mem_req_ready  in  1  memory accepts a request this cycle.
- mem_req_valid  out  1  read request pending.
- memory_address  out  ADDR_W  byte address of the pending request.
- memory_data_valid  in  1  one in-order response word returned this cycle.
- fsm_busy  out  1  fill in progress; pipeline must stall.
- write_data_array  out  1  write the returned word at cache_address.
- write_tag_array  out  1  write the tag for the line (last word only).
- cache_address  out  ADDR_W  byte address of the word being written.
- fill_done  out  1  one-cycle pulse after the line completes.

## Operation
- Derived widths: OFF_W = log2(LINE_WORDS·WORD_BYTES); IDX_W = log2(LINE_WORDS); counters are IDX_W+1 bits.
- States: IDLE, FILL, DONE.
  - IDLE→FILL when miss_detected=1.
  - FILL→DONE on the cycle the LINE_WORDS-th response is accepted.
  - DONE→IDLE unconditionally.
- On the miss, capture:
  - base = miss_address with the low OFF_W bits cleared.
  - start = miss_address[OFF_W-1 : log2(WORD_BYTES)] if CWF=1, else 0.
  - Clear req_cnt and rsp_cnt.
- Request side (FILL):
  - mem_req_valid = (req_cnt < LINE_WORDS).
  - memory_address = base + (((start+req_cnt) mod LINE_WORDS) · WORD_BYTES).
  - req_cnt increments on mem_req_valid & mem_req_ready.
  - Address and valid are held stable while ready is low.
- Response side (FILL):
  - Each memory_data_valid with rsp_cnt < req_cnt asserts write_data_array in the same cycle.
  - cache_address = base + (((start+rsp_cnt) mod LINE_WORDS) · WORD_BYTES).
  - rsp_cnt increments on each accepted response.
  - write_tag_array = write_data_array & (rsp_cnt == LINE_WORDS-1).
- Index arithmetic wraps mod LINE_WORDS. Because base is aligned, the address sum never carries out of the line.
- fsm_busy = (state≠IDLE) | miss_detected. It is combinational so the stall applies in the miss cycle.
- fill_done = 1 in DONE only.
- Ignored inputs:
  - miss_detected outside IDLE.
  - memory_data_valid in IDLE or DONE.
  - memory_data_valid with rsp_cnt == req_cnt (response with no outstanding request): no write, no count.

## Timing
- Reset values: state=IDLE, counters=0, base=0, start=0.
  - mem_req_valid, write_data_array, write_tag_array and fill_done are all 0.
  - memory_address = 0 and cache_address = 0.
  - fsm_busy follows miss_detected.
- Miss in cycle T: first request is valid in T+1. With ready held high, requests occupy T+1 … T+LINE_WORDS.
- Responses may arrive from T+2 (requests are accepted at a clock edge). There is no maximum latency; gaps are allowed.
- Last response in cycle R: write_data_array=1 and write_tag_array=1 in R; fill_done=1 and fsm_busy=1 in R+1; IDLE in R+2.
  - A miss in R+2 starts a new fill.
- Simultaneous request handshake and response in one cycle: both counters update.
- rst mid-fill: IDLE on the next edge with all outputs deasserted. Stale responses afterwards are ignored. A miss asserted together with rst is not captured.

## Structure
- Shared package cache_fill_pkg:
  - state enum {IDLE, FILL, DONE}.
  - Functions/localparams for OFF_W and IDX_W.
- Sub-module fill_word_counter (parametrised IDX_W+1-bit clear/increment counter that outputs the wrapped word index from start), instantiated twice: request and response.
- Remaining logic is the state register, base/start capture registers, and two address adders.

## Test plan
- Defaults, CWF=0, miss_address=0x1236, ready=1, responses 3 cycles after each request:
  - memory_address runs 0x1230, 0x1232 … 0x123E.
  - cache_address follows in the same order.
  - write_tag_array is asserted only with the 0x123E write; fill_done follows one cycle later.
- CWF=1, miss_address=0x123A: request order is 0x123A, 0x123C, 0x123E, 0x1230 … 0x1238; the tag write coincides with 0x1238.
- mem_req_ready low for 4 cycles after the second request: mem_req_valid and memory_address stay held; exactly 8 requests and 8 writes occur.
- memory_data_valid pulsed in IDLE, and a second miss_detected asserted mid-fill: no write, no state change, the fill address is unchanged.
- rst asserted after 3 of 8 responses: next cycle all outputs are 0; later memory_data_valid pulses produce no write; a new miss to 0x0040 fills 0x0040–0x004E cleanly.
- LINE_WORDS=4, WORD_BYTES=4, ADDR_W=32, miss 0xFFFF_FFF4: addresses are 0xFFFF_FFF0, F4, F8, FC with no wrap past the line.
